// File: rtl/led_sequence_blinker.sv
// Multi-LED blink sequencer: latches a blink mode on a start edge and plays whole on/off blinks.
// Optional feature: define BLINKER_RETRIGGER_EN to let a start edge restart a running sequence.
module led_sequence_blinker #(
  parameter int unsigned LED_W = 1,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned NB_W  = 4,
  parameter int unsigned ON0   = 6000000,
  parameter int unsigned OFF0  = 12000000,
  parameter int unsigned N0    = 3,
  parameter int unsigned ON1   = 2400000,
  parameter int unsigned OFF1  = 2400000,
  parameter int unsigned N1    = 5
) (
  input  logic             i_hwclk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_blink_type,
  input  logic [CNT_W-1:0] i_cfg_on,
  input  logic [CNT_W-1:0] i_cfg_off,
  input  logic [NB_W-1:0]  i_cfg_count,
  input  logic [LED_W-1:0] i_led_mask,
  input  logic             i_abort,
  output logic [LED_W-1:0] o_led,
  output logic             o_busy,
  output logic             o_done
);

`ifdef BLINKER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t           r_state;
  logic             r_start_q;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_on_last;
  logic [CNT_W-1:0] r_off_last;
  logic [NB_W-1:0]  r_cnt;
  logic [LED_W-1:0] r_mask;
  logic [LED_W-1:0] r_led;
  logic             r_busy;
  logic             r_done;

  logic             w_start_edge;
  logic             w_load;
  logic [CNT_W-1:0] w_on_sel;
  logic [CNT_W-1:0] w_off_sel;
  logic [NB_W-1:0]  w_cnt_sel;
  logic [CNT_W-1:0] w_on_last;
  logic [CNT_W-1:0] w_off_last;

  assign w_start_edge = i_start & ~r_start_q;
  assign w_load       = w_start_edge & ((r_state == S_IDLE) | RETRIG);

  // Mode decode; steady reuses the error on-time with a single blink.
  always_comb begin
    w_on_sel  = CNT_W'(ON0);
    w_off_sel = CNT_W'(OFF0);
    w_cnt_sel = NB_W'(N0);
    case (i_blink_type)
      2'd1: begin
        w_on_sel  = CNT_W'(ON1);
        w_off_sel = CNT_W'(OFF1);
        w_cnt_sel = NB_W'(N1);
      end
      2'd2: begin
        w_on_sel  = i_cfg_on;
        w_off_sel = i_cfg_off;
        w_cnt_sel = i_cfg_count;
      end
      2'd3: w_cnt_sel = NB_W'(1);
      default: ;
    endcase
  end

  // Terminal timer values; a zero duration behaves as one cycle.
  assign w_on_last  = (w_on_sel  == '0) ? '0 : w_on_sel  - CNT_W'(1);
  assign w_off_last = (w_off_sel == '0) ? '0 : w_off_sel - CNT_W'(1);

  always_ff @(posedge i_hwclk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_timer    <= '0;
      r_on_last  <= '0;
      r_off_last <= '0;
      r_cnt      <= '0;
      r_mask     <= '0;
      r_led      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_start_q <= i_start;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_timer <= '0;
        r_cnt   <= '0;
        r_led   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_load) begin
        r_on_last  <= w_on_last;
        r_off_last <= w_off_last;
        r_cnt      <= w_cnt_sel;
        r_mask     <= i_led_mask;
        r_timer    <= '0;
        r_busy     <= 1'b1;
        // A zero-blink request completes immediately without lighting the LEDs.
        if (w_cnt_sel == '0) begin
          r_state <= S_IDLE;
          r_led   <= '0;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_ON;
          r_led   <= i_led_mask;
          r_done  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_led  <= '0;
            r_busy <= 1'b0;
          end
          S_ON: begin
            if (r_timer == r_on_last) begin
              r_timer <= '0;
              r_led   <= '0;
              if (r_cnt == NB_W'(1)) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_OFF;
                r_cnt   <= r_cnt - NB_W'(1);
              end
            end else begin
              r_timer <= r_timer + CNT_W'(1);
            end
          end
          S_OFF: begin
            if (r_timer == r_off_last) begin
              r_timer <= '0;
              r_state <= S_ON;
              r_led   <= r_mask;
            end else begin
              r_timer <= r_timer + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_led_sequence_blinker.sv
// Bench for led_sequence_blinker: directed scenarios plus random sequences against a waveform model.
// Honours BLINKER_RETRIGGER_EN for the mid-sequence start scenario.
module tb_led_sequence_blinker;
  localparam int unsigned LED_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NB_W  = 4;
  localparam int M_ON0 = 4, M_OFF0 = 8, M_N0 = 3, M_ON1 = 2, M_OFF1 = 2, M_N1 = 5;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [1:0]       btype;
  logic [CNT_W-1:0] cfg_on, cfg_off;
  logic [NB_W-1:0]  cfg_count;
  logic [LED_W-1:0] mask;
  logic [LED_W-1:0] led;
  logic             busy, done;

  int total = 0;
  int bad   = 0;

  led_sequence_blinker #(
    .LED_W(LED_W), .CNT_W(CNT_W), .NB_W(NB_W),
    .ON0(4), .OFF0(8), .N0(3), .ON1(2), .OFF1(2), .N1(5)
  ) dut (
    .i_hwclk(clk), .i_rst(rst), .i_start(start), .i_blink_type(btype),
    .i_cfg_on(cfg_on), .i_cfg_off(cfg_off), .i_cfg_count(cfg_count),
    .i_led_mask(mask), .i_abort(abort),
    .o_led(led), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Blink parameters as the mode table defines them (zero durations count as one cycle).
  task automatic mode_params(input logic [1:0] t, input int con, input int coff, input int ccnt,
                             output int on, output int off, output int n);
    case (t)
      2'd0: begin on = M_ON0; off = M_OFF0; n = M_N0; end
      2'd1: begin on = M_ON1; off = M_OFF1; n = M_N1; end
      2'd2: begin on = (con == 0) ? 1 : con; off = (coff == 0) ? 1 : coff; n = ccnt; end
      default: begin on = M_ON0; off = M_OFF0; n = 1; end
    endcase
  endtask

  // Expected {led,busy,done} j cycles after the start edge was sampled.
  function automatic logic [5:0] exp_out(input int on, input int off, input int n,
                                         input logic [3:0] m, input int j);
    int len, p;
    if (n == 0) return (j == 0) ? {4'h0, 1'b1, 1'b1} : {4'h0, 1'b0, 1'b1};
    len = n * on + (n - 1) * off;
    if (j >= len) return {4'h0, 1'b0, 1'b1};
    p = j % (on + off);
    return {(p < on) ? m : 4'h0, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {led, busy, done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one sequence and checks every cycle through completion.
  task automatic run_seq(input string tag, input logic [1:0] t, input int con, input int coff,
                         input int ccnt, input logic [3:0] m, input bit scramble, input bit hold);
    int on, off, n, len;
    mode_params(t, con, coff, ccnt, on, off, n);
    len = (n == 0) ? 1 : n * on + (n - 1) * off;
    btype = t; cfg_on = CNT_W'(con); cfg_off = CNT_W'(coff); cfg_count = NB_W'(ccnt); mask = m;
    start = 1'b1;
    for (int j = 0; j <= len + 2; j++) begin
      tick();
      if (!hold) start = 1'b0;
      chk(tag, exp_out(on, off, n, m, j));
      if (scramble) begin
        btype = 2'($urandom); cfg_on = CNT_W'($urandom_range(0, 9));
        cfg_off = CNT_W'($urandom_range(0, 9)); cfg_count = NB_W'($urandom);
        mask = 4'($urandom);
      end
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    int on, off, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; btype = 2'd0;
    cfg_on = '0; cfg_off = '0; cfg_count = '0; mask = '0;
    repeat (3) tick();
    chk("reset", 6'b0000_0_0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 6'b0000_0_0);

    run_seq("error_mode", 2'd0, 0, 0, 0, 4'hF, 1'b0, 1'b0);
    run_seq("success_mode", 2'd1, 0, 0, 0, 4'hA, 1'b0, 1'b0);
    run_seq("custom_zero_on", 2'd2, 0, 3, 2, 4'b0101, 1'b0, 1'b0);
    run_seq("custom_zero_count", 2'd2, 0, 3, 0, 4'b0101, 1'b0, 1'b0);
    run_seq("steady_mode", 2'd3, 7, 7, 9, 4'h6, 1'b0, 1'b0);
    run_seq("held_start", 2'd1, 0, 0, 0, 4'hF, 1'b0, 1'b1);

    // Abort during the second ON phase of an error sequence.
    btype = 2'd0; mask = 4'hF; start = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      tick(); start = 1'b0;
      chk("abort_pre", exp_out(M_ON0, M_OFF0, M_N0, 4'hF, j));
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort_next", 6'b0000_0_0);
    tick();
    chk("abort_idle", 6'b0000_0_0);

    // Abort wins over a coincident start edge; the held start must not fire later.
    start = 1'b1; abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort_vs_start", 6'b0000_0_0);
    repeat (2) tick();
    chk("abort_held_start", 6'b0000_0_0);
    start = 1'b0;
    tick();

    // Start edge while a sequence is running.
    btype = 2'd0; mask = 4'hF; start = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      tick(); start = 1'b0;
      chk("retrig_pre", exp_out(M_ON0, M_OFF0, M_N0, 4'hF, j));
    end
    btype = 2'd1; mask = 4'h3; start = 1'b1;
`ifdef BLINKER_RETRIGGER_EN
    for (int k = 0; k <= 18; k++) begin
      tick(); start = 1'b0;
      chk("retrig_new", exp_out(M_ON1, M_OFF1, M_N1, 4'h3, k));
    end
`else
    for (int j = 6; j <= 28; j++) begin
      tick(); start = 1'b0;
      chk("retrig_ignored", exp_out(M_ON0, M_OFF0, M_N0, 4'hF, j));
    end
`endif
    tick();

    // Reset in the middle of an OFF phase, then a normal run.
    btype = 2'd0; mask = 4'hF; start = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick(); start = 1'b0;
      chk("rst_pre", exp_out(M_ON0, M_OFF0, M_N0, 4'hF, j));
    end
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_mid_off", 6'b0000_0_0);
    tick();
    chk("rst_released", 6'b0000_0_0);
    run_seq("after_rst", 2'd1, 0, 0, 0, 4'h9, 1'b0, 1'b0);

    // Random modes and configurations with busy-time input scrambling.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] t;
      t = 2'($urandom);
      run_seq("random", t, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), 4'($urandom), 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
